regfile_wr_sched: RTL
=====================

Name: regfile_wr_sched

Overview:
- Write-port scheduler for the 32 x 64-bit register file built from enable-gated 64-bit registers.
- Shares the file's single write port between NREQ requesters (e.g. ALU writeback, load writeback) using round-robin arbitration with valid/ready handshakes.
- Drives the one-hot per-register enable vector and the shared write-data bus; writes to X31 (zero register) are discarded.

Parameters:
- NREQ, 2, number of requesters (2..4)
- DATA_W, 64, write data width
- NREGS, 32, register count; address width = $clog2(NREGS)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low: asserted when 0, released on a clk edge
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*5  per-requester destination register, requester i at [5i+4:5i]
- req_data  in  NREQ*DATA_W  per-requester write data
- req_ready  out  NREQ  one-hot grant; transfer when valid & ready in the same cycle
- hold  in  1  freeze: no new grants while 1
- reg_en  out  NREGS  one-hot write enable, one bit per register enable input
- wr_data  out  DATA_W  shared data to every register input
- busy  out  1  write stage occupied (reg_en nonzero or X31 drop in flight)

Behaviour:
- Reset (reset=0): reg_en=0, wr_data=0, busy=0, stage valid=0, round-robin pointer=0. Takes effect immediately, independent of clk. An in-flight write is dropped, not completed.
- req_ready is combinational from req_valid, hold and the pointer.
  - Zero when hold=1 or no request is valid.
  - Otherwise exactly one bit set: the first valid requester at or after the pointer, wrapping modulo NREQ.
- On a transfer at edge k:
  - The stage captures addr/data and sets valid.
  - Pointer becomes (granted index + 1) mod NREQ.
  - No transfer: pointer holds.
- The write stage drains every cycle, so it never back-pressures. Only hold blocks grants.
- After edge k:
  - reg_en = decode(addr) and wr_data = data.
  - The register file captures at edge k+1. Issue-to-commit latency is 2 edges.
  - Back-to-back transfers give one write per cycle.
- No transfer at edge k: stage valid=0 and reg_en=0 after k. wr_data holds its last value.
- addr == 31: stage valid=1, busy=1, reg_en=0 (write discarded).
- busy equals stage valid.
- Requester rules:
  - Keep req_valid/addr/data stable until ready.
  - Deassertion before ready is permitted; the request is then simply not granted.
- hold rising while a write is in the stage: that write still completes. hold affects only new grants.
- Two requesters targeting the same register in consecutive cycles: both commit in grant order, later data wins.
- NREQ requesters continuously valid, hold=0: grants rotate 0,1,..,NREQ-1,0. Worst-case wait is NREQ-1 cycles.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - Adds ports byp_addr (in, 5), byp_hit (out, 1), byp_data (out, DATA_W).
  - byp_hit = stage valid & stage addr == byp_addr & byp_addr != 31, combinational.
  - byp_data = stage data when hit, else 0.
  - Lets readers see a write one cycle before the register captures it.
- Undefined: ports absent, no bypass logic. All other behaviour identical.

Decomposition:
- Package regfile_pkg:
  - NREGS=32, ADDR_W=5, DATA_W=64, ZERO_REG=5'd31
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [63:0])
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, hold, clk, reset.
  - Outputs: one-hot gnt and the internal pointer.
  - Reused elsewhere for read-port sharing.
- The decoder stays inline.

Test Plan:
- Reset mid-write: transfer addr=3 data=64'hAAAA, then drive reset=0 between edges -> reg_en=0, busy=0 immediately. After release, with no request pending, no write occurs.
- Single write: req0 addr=5 data=64'hDEADBEEF_00000001 -> ready0=1 that cycle. Next cycle reg_en=32'h0000_0020 and wr_data matches.
- Contention: req0 (addr=1, data=1) and req1 (addr=2, data=2) both valid from reset -> grants 0, 1, 0, 1 with pointer alternating. reg_en sequence 0x2, 0x4.
- Zero register: req1 addr=31 data=64'hFFFF -> ready1=1, busy=1 next cycle, reg_en=0.
- Hold: hold=1 with req0 valid for 3 cycles -> ready=0 throughout, reg_en=0. hold=0 -> grant next cycle. A write already staged before hold still commits.
- Bypass (RF_BYPASS_EN defined): stage holds addr=7 data=64'h1234 and byp_addr=7 -> byp_hit=1, byp_data=64'h1234. byp_addr=8 -> byp_hit=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the 32 x 64-bit integer register file.
package regfile_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // X31 reads as zero, so writes to it are dropped
  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a freeze input; the search starts at the pointer and wraps modulo N.
// Shared by the register-file write scheduler and the read-port sharing logic.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          hold,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic found;
  int   cand;
  int   gidx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = 0;
    gidx  = 0;
    if (!hold) begin
      for (int off = 0; off < N; off++) begin
        cand = (int'(ptr) + off) % N;
        for (int i = 0; i < N; i++) begin
          if (!found && (i == cand) && req[i]) begin
            gnt[i] = 1'b1;
            gidx   = i;
            found  = 1'b1;
          end
        end
      end
    end
  end

  // Pointer moves just past the winner, so it has lowest priority next time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PW'((gidx + 1) % N);
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32 x 64-bit register file: round-robin grant, one-cycle write stage.
// Optional macro RF_BYPASS_EN adds a forwarding port that exposes the staged write to readers.
module regfile_wr_sched #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 64,
  parameter int NREGS  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ*regfile_pkg::ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]              req_data,
  output logic [NREQ-1:0]                     req_ready,
  input  logic                                hold,
  output logic [NREGS-1:0]                    reg_en,
  output logic [DATA_W-1:0]                   wr_data,
`ifdef RF_BYPASS_EN
  input  regfile_pkg::reg_addr_t              byp_addr,
  output logic                                byp_hit,
  output logic [DATA_W-1:0]                   byp_data,
`endif
  output logic                                busy
);

  import regfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     rr_ptr_unused;
  reg_addr_t         sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              vld_p0;
  reg_addr_t         addr_p0;
  logic [DATA_W-1:0] data_p0;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .hold  (hold),
    .gnt   (gnt),
    .ptr   (rr_ptr_unused)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p0: granted write; drains every cycle so it never back-pressures.
  // Data keeps its last value when idle, which is what wr_data shows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= |gnt;
      if (|gnt) begin
        addr_p0 <= sel_addr;
        data_p0 <= sel_data;
      end
    end
  end

  always_comb begin
    reg_en = '0;
    if (vld_p0 && (addr_p0 != ZERO_REG)) begin
      for (int r = 0; r < NREGS; r++) begin
        reg_en[r] = (addr_p0 == ADDR_W'(r));
      end
    end
  end

  assign wr_data = data_p0;
  assign busy    = vld_p0;

`ifdef RF_BYPASS_EN
  assign byp_hit  = vld_p0 && (addr_p0 == byp_addr) && (byp_addr != ZERO_REG);
  assign byp_data = byp_hit ? data_p0 : '0;
`endif

endmodule
